// File: rtl/inst_queue.sv
// Dual-write, dual-read circular instruction queue between fetch and issue.
// Fetch pushes up to two {pc,inst} entries per cycle; issue pops up to two.
module inst_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic [63:0]   w_data_1,
  input  logic          w_en_1,
  input  logic [63:0]   w_data_2,
  input  logic          w_en_2,
  output logic          fifo_stall,
  output logic [63:0]   fifo_r_data_1,
  output logic          fifo_r_data_1_ok,
  output logic [63:0]   fifo_r_data_2,
  output logic          fifo_r_data_2_ok,
  input  logic          p_data_1,
  input  logic          p_data_2,
  output logic [AW:0]   count
);

  localparam logic [AW:0] StallLevel = (AW + 1)'(DEPTH - 2);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] head_p1, tail_p1;
  logic [1:0]    pops, pushes;
  logic          ok_1, ok_2, accept;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  assign ok_1       = (count_q != '0);
  assign ok_2       = (count_q > (AW + 1)'(1));
  // Stall looks only at registered occupancy so fetch never sees a pop-dependent path.
  assign fifo_stall = (count_q > StallLevel);
  assign accept     = w_en_1 & ~fifo_stall & ~flush;

  always_comb begin
    pops = 2'd0;
    if (p_data_1 && ok_1) begin
      pops = (p_data_2 && ok_2) ? 2'd2 : 2'd1;
    end
    pushes = 2'd0;
    if (accept) begin
      pushes = w_en_2 ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    head_d  = head_q + AW'(pops);
    tail_d  = tail_q + AW'(pushes);
    count_d = count_q + (AW + 1)'(pushes) - (AW + 1)'(pops);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[tail_q] <= w_data_1;
      if (w_en_2) begin
        mem[tail_p1] <= w_data_2;
      end
    end
  end

  assign fifo_r_data_1_ok = ok_1;
  assign fifo_r_data_2_ok = ok_2;
  assign fifo_r_data_1    = ok_1 ? mem[head_q]  : 64'h0;
  assign fifo_r_data_2    = ok_2 ? mem[head_p1] : 64'h0;
  assign count            = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Randomized bench for inst_queue against a queue-based reference model.
module tb_inst_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic [63:0]   w_data_1, w_data_2;
  logic          w_en_1, w_en_2;
  logic          fifo_stall;
  logic [63:0]   fifo_r_data_1, fifo_r_data_2;
  logic          fifo_r_data_1_ok, fifo_r_data_2_ok;
  logic          p_data_1, p_data_2;
  logic [AW:0]   count;

  int            n_checks = 0;
  int            n_bad    = 0;
  logic [63:0]   model_q[$];
  logic [31:0]   pc_ctr = 32'h1000;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .flush            (flush),
    .w_data_1         (w_data_1),
    .w_en_1           (w_en_1),
    .w_data_2         (w_data_2),
    .w_en_2           (w_en_2),
    .fifo_stall       (fifo_stall),
    .fifo_r_data_1    (fifo_r_data_1),
    .fifo_r_data_1_ok (fifo_r_data_1_ok),
    .fifo_r_data_2    (fifo_r_data_2),
    .fifo_r_data_2_ok (fifo_r_data_2_ok),
    .p_data_1         (p_data_1),
    .p_data_2         (p_data_2),
    .count            (count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = model_q.size();
    check_eq("count", 64'(count), 64'(sz));
    check_eq("ok_1", 64'(fifo_r_data_1_ok), 64'(sz >= 1));
    check_eq("ok_2", 64'(fifo_r_data_2_ok), 64'(sz >= 2));
    check_eq("stall", 64'(fifo_stall), 64'(sz > DEPTH - 2));
    check_eq("r_data_1", fifo_r_data_1, (sz >= 1) ? model_q[0] : 64'h0);
    check_eq("r_data_2", fifo_r_data_2, (sz >= 2) ? model_q[1] : 64'h0);
  endtask

  task automatic next_entry(output logic [63:0] e);
    e = {pc_ctr, $urandom()};
    pc_ctr += 32'd4;
  endtask

  // Drive one cycle of inputs, advance the model, then sample just after the edge.
  task automatic step(input logic f, input logic e1, input logic e2, input logic c1,
                      input logic c2);
    logic [63:0] d1, d2, dummy;
    int          np;
    bit          stalled;
    next_entry(d1);
    next_entry(d2);
    flush = f; w_en_1 = e1; w_en_2 = e2; w_data_1 = d1; w_data_2 = d2;
    p_data_1 = c1; p_data_2 = c2;
    stalled = (model_q.size() > DEPTH - 2);
    if (f) begin
      model_q.delete();
    end else begin
      np = (c1 && model_q.size() >= 1) ? ((c2 && model_q.size() >= 2) ? 2 : 1) : 0;
      for (int k = 0; k < np; k++) dummy = model_q.pop_front();
      if (e1 && !stalled) begin
        model_q.push_back(d1);
        if (e2) model_q.push_back(d2);
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          pw, pp;
    resetn = 1'b0; flush = 1'b0; w_en_1 = 1'b0; w_en_2 = 1'b0;
    w_data_1 = '0; w_data_2 = '0; p_data_1 = 1'b0; p_data_2 = 1'b0;
    #12;
    check_all();
    @(negedge clk);
    resetn = 1'b1;

    // Single push becomes visible one cycle later.
    step(0, 1, 0, 0, 0);
    // Two pairs then pop two: order preserved.
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    // Fill to 15, then push while stalled, then drain two.
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    check_eq("fill15", 64'(count), 64'd15);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    check_eq("stall_hold", 64'(count), 64'd15);
    step(0, 0, 0, 1, 1);
    check_eq("stall_clear", 64'(fifo_stall), 64'd0);

    // Wrap: steady push 2 / pop 2 with sequential pcs.
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    exp_pc = fifo_r_data_1[63:32];
    check_eq("wrap_start", 64'(exp_pc), 64'(model_q[0][63:32]));
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, 1, 1);
      exp_pc += 32'd8;
      check_eq("wrap_pc", 64'(fifo_r_data_1[63:32]), 64'(exp_pc));
      check_eq("wrap_pc2", 64'(fifo_r_data_2[63:32]), 64'(exp_pc + 32'd4));
    end

    // Flush wins over same-cycle push and pop at count=6.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    check_eq("pre_flush", 64'(count), 64'd6);
    step(1, 1, 1, 1, 0);
    check_eq("post_flush", 64'(count), 64'd0);

    // count=1: second pop ignored, push of 2 gives count=2.
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    check_eq("pop2_ignored", 64'(count), 64'd2);
    // p_data_2 without p_data_1 does nothing.
    step(0, 0, 0, 0, 1);

    // Randomized phases: fill-heavy, drain-heavy, balanced.
    for (int i = 0; i < 1500; i++) begin
      case ((i / 100) % 3)
        0:       begin pw = 85; pp = 30; end
        1:       begin pw = 30; pp = 85; end
        default: begin pw = 60; pp = 60; end
      endcase
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 99) < pw, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < pp, $urandom_range(0, 1) == 1);
      if (i == 750) begin
        // Asynchronous reset mid-cycle clears everything.
        #2 resetn = 1'b0;
        model_q.delete();
        #1 check_all();
        @(negedge clk);
        resetn = 1'b1;
      end
    end

    flush = 1'b0; w_en_1 = 1'b0; p_data_1 = 1'b0;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
